// File: rtl/div_sched.sv
// Round-robin scheduler sharing one free-running pipelined divider among NREQ
// requesters; tracks in-flight slots by tag and enforces per-requester credits.
module div_sched #(
    parameter int unsigned NREQ           = 2,
    parameter int unsigned IDW            = 1,
    parameter int unsigned DIVIDEND_WIDTH = 21,
    parameter int unsigned DIVISOR_WIDTH  = 12,
    parameter int unsigned OUTPUT_WIDTH   = 22,
    parameter int unsigned PIPE_SLOTS     = 9,
    parameter int unsigned MAX_OUT        = 3
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic [NREQ-1:0]                req_valid,
    output logic [NREQ-1:0]                req_ready,
    input  logic [NREQ*DIVIDEND_WIDTH-1:0] req_dividend,
    input  logic [NREQ*DIVISOR_WIDTH-1:0]  req_divisor,
    output logic [DIVIDEND_WIDTH-1:0]      div_dividend,
    output logic [DIVISOR_WIDTH-1:0]       div_divisor,
    input  logic                           div_pull,
    input  logic                           div_push,
    input  logic [OUTPUT_WIDTH-1:0]        div_quotient,
    output logic                           res_valid,
    output logic [IDW-1:0]                 res_id,
    output logic [OUTPUT_WIDTH-1:0]        res_quotient,
    output logic                           busy
);
    localparam int unsigned   CW         = $clog2(MAX_OUT + 1);
    localparam logic [CW-1:0] CREDIT_MAX = CW'(MAX_OUT);

    logic [IDW-1:0]        rr_ptr;
    logic [CW-1:0]         credit [NREQ];
    logic [PIPE_SLOTS-1:0] tag_valid;
    logic [IDW-1:0]        tag_id [PIPE_SLOTS];

    logic                      grant_any;
    logic [IDW-1:0]            grant_id;
    logic [IDW-1:0]            cand;
    logic [DIVIDEND_WIDTH-1:0] win_dividend;
    logic [DIVISOR_WIDTH-1:0]  win_divisor;
    logic                      retire;
    logic [IDW-1:0]            tail_id;

    // Grant only in the pull cycle; rst gates the combinational path so the
    // grant is visibly dropped while reset is held.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        cand      = '0;
        req_ready = '0;
        if (rst && div_pull && !flush) begin
            for (int unsigned i = 1; i <= NREQ; i++) begin
                cand = IDW'((int'(rr_ptr) + i) % NREQ);
                if (!grant_any && req_valid[cand] && (credit[cand] < CREDIT_MAX)) begin
                    grant_any = 1'b1;
                    grant_id  = cand;
                end
            end
            if (grant_any) req_ready[grant_id] = 1'b1;
        end
    end

    always_comb begin
        win_dividend = '0;
        win_divisor  = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (grant_id == IDW'(k)) begin
                win_dividend = req_dividend[k*DIVIDEND_WIDTH +: DIVIDEND_WIDTH];
                win_divisor  = req_divisor[k*DIVISOR_WIDTH +: DIVISOR_WIDTH];
            end
        end
    end

    // The push looks at the pre-shift tail, so a coincident pull is harmless.
    assign retire  = div_push && tag_valid[PIPE_SLOTS-1];
    assign tail_id = tag_id[PIPE_SLOTS-1];
    assign busy    = |tag_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr       <= '0;
            div_dividend <= '0;
            div_divisor  <= '0;
            res_valid    <= 1'b0;
            res_id       <= '0;
            res_quotient <= '0;
            tag_valid    <= '0;
            for (int unsigned k = 0; k < NREQ; k++) credit[k] <= '0;
            for (int unsigned i = 0; i < PIPE_SLOTS; i++) tag_id[i] <= '0;
        end else begin
            res_valid <= retire && !flush;
            if (retire && !flush) begin
                res_id       <= tail_id;
                res_quotient <= div_quotient;
            end

            if (grant_any) begin
                rr_ptr       <= grant_id;
                div_dividend <= win_dividend;
                div_divisor  <= win_divisor;
            end

            if (div_pull) begin
                tag_valid[0] <= grant_any;
                tag_id[0]    <= grant_id;
                for (int unsigned i = 1; i < PIPE_SLOTS; i++) begin
                    tag_valid[i] <= tag_valid[i-1];
                    tag_id[i]    <= tag_id[i-1];
                end
            end

            for (int unsigned k = 0; k < NREQ; k++) begin
                if (flush) begin
                    credit[k] <= '0;
                end else if (grant_any && (grant_id == IDW'(k))) begin
                    if (!(retire && (tail_id == IDW'(k))))
                        credit[k] <= credit[k] + 1'b1;
                end else if (retire && (tail_id == IDW'(k)) && (credit[k] != '0)) begin
                    credit[k] <= credit[k] - 1'b1;
                end
            end

            if (flush) tag_valid <= '0;
        end
    end
endmodule

// File: tb/tb_div_sched.sv
// Self-checking bench for div_sched: emulated divider plus a slot-indexed
// reference model of grants, credits and returned results.
module tb_div_sched;
    localparam int NREQ  = 2;
    localparam int IDW   = 1;
    localparam int DW    = 21;
    localparam int SW    = 12;
    localparam int OW    = 22;
    localparam int PS    = 9;
    localparam int MO    = 3;
    localparam int NSLOT = 2048;

    logic                 clk;
    logic                 rst;
    logic                 flush;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*DW-1:0]   req_dividend;
    logic [NREQ*SW-1:0]   req_divisor;
    logic [DW-1:0]        div_dividend;
    logic [SW-1:0]        div_divisor;
    logic                 div_pull;
    logic                 div_push;
    logic [OW-1:0]        div_quotient;
    logic                 res_valid;
    logic [IDW-1:0]       res_id;
    logic [OW-1:0]        res_quotient;
    logic                 busy;

    div_sched #(
        .NREQ(NREQ), .IDW(IDW), .DIVIDEND_WIDTH(DW), .DIVISOR_WIDTH(SW),
        .OUTPUT_WIDTH(OW), .PIPE_SLOTS(PS), .MAX_OUT(MO)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_dividend(req_dividend), .req_divisor(req_divisor),
        .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_pull(div_pull), .div_push(div_push), .div_quotient(div_quotient),
        .res_valid(res_valid), .res_id(res_id), .res_quotient(res_quotient),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int errors;

    // Per-pull-index slot records: slot j is presented at the push made when
    // exactly j+PS pulls have already happened.
    int             pulls;
    bit             s_valid [NSLOT];
    int             s_id    [NSLOT];
    logic [OW-1:0]  s_q     [NSLOT];
    logic [OW-1:0]  divq    [NSLOT];

    int             m_ptr;
    int             m_credit [NREQ];
    int             obs_out  [NREQ];
    bit             exp_rv;
    int             exp_rid;
    logic [OW-1:0]  exp_rq;

    logic signed [DW-1:0] opd [NREQ];
    logic signed [SW-1:0] ops [NREQ];

    int             n_pulses;
    int             last_id;
    logic [OW-1:0]  last_q;
    logic [NREQ-1:0] last_ready;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Quotient of (a * 2^6) / b, truncating toward zero.
    function automatic logic [OW-1:0] qf(input logic signed [DW-1:0] a, input logic signed [SW-1:0] b);
        longint n;
        longint d;
        n = longint'(a) * 64;
        d = longint'(b);
        if (d == 0) return '0;
        return OW'(n / d);
    endfunction

    function automatic bit model_busy();
        for (int j = pulls - PS; j < pulls; j++)
            if (j >= 0 && s_valid[j]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic clear_window();
        for (int j = pulls - PS; j < pulls; j++)
            if (j >= 0) s_valid[j] = 1'b0;
    endtask

    task automatic model_reset();
        m_ptr  = 0;
        exp_rv = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            m_credit[k] = 0;
            obs_out[k]  = 0;
        end
        clear_window();
    endtask

    task automatic check_zero(input string pfx);
        chk({pfx, "_req_ready"}, req_ready, 0);
        chk({pfx, "_res_valid"}, res_valid, 0);
        chk({pfx, "_res_id"}, res_id, 0);
        chk({pfx, "_res_quotient"}, res_quotient, 0);
        chk({pfx, "_div_dividend"}, div_dividend, 0);
        chk({pfx, "_div_divisor"}, div_divisor, 0);
        chk({pfx, "_busy"}, busy, 0);
    endtask

    task automatic step(input bit pull, input bit push, input bit fl, input logic [NREQ-1:0] v);
        int             win;
        int             tail;
        bit             nrv;
        int             nid;
        logic [OW-1:0]  nq;
        logic [NREQ-1:0] exp_ready;
        @(negedge clk);
        chk("res_valid", res_valid, exp_rv);
        if (exp_rv) begin
            chk("res_id", res_id, exp_rid);
            chk("res_quotient", res_quotient, exp_rq);
        end
        if (res_valid) begin
            chk("credit_underflow", obs_out[res_id] > 0, 1);
            if (obs_out[res_id] > 0) obs_out[res_id]--;
            n_pulses++;
            last_id = res_id;
            last_q  = res_quotient;
        end

        div_pull  = pull;
        div_push  = push;
        flush     = fl;
        req_valid = v;
        for (int k = 0; k < NREQ; k++) begin
            req_dividend[k*DW +: DW] = opd[k];
            req_divisor[k*SW +: SW]  = ops[k];
        end
        tail = pulls - PS;
        div_quotient = (tail >= 0) ? divq[tail] : OW'($urandom);
        #1;

        win = -1;
        if (pull && !fl)
            for (int i = 1; i <= NREQ; i++) begin
                int k;
                k = (m_ptr + i) % NREQ;
                if (win < 0 && v[k] && m_credit[k] < MO) win = k;
            end
        exp_ready = '0;
        if (win >= 0) exp_ready[win] = 1'b1;
        chk("req_ready", req_ready, exp_ready);
        chk("busy", busy, model_busy());
        if (pull) last_ready = req_ready;
        for (int k = 0; k < NREQ; k++)
            if (req_ready[k]) begin
                obs_out[k]++;
                chk("in_flight", obs_out[k] <= MO, 1);
            end

        nrv = 1'b0;
        nid = 0;
        nq  = '0;
        if (push && tail >= 0 && s_valid[tail] && !fl) begin
            nrv = 1'b1;
            nid = s_id[tail];
            nq  = s_q[tail];
            m_credit[nid]--;
        end
        if (win >= 0) begin
            m_credit[win]++;
            m_ptr = win;
        end
        if (pull) begin
            if (pulls >= NSLOT) begin
                $display("FAIL slot_table: observed %0d pulls, limit %0d", pulls, NSLOT);
                $fatal(1, "slot table exhausted");
            end
            if (pulls > 0) divq[pulls-1] = qf(div_dividend, div_divisor);
            s_valid[pulls] = (win >= 0);
            s_id[pulls]    = win;
            s_q[pulls]     = (win >= 0) ? qf(opd[win], ops[win]) : '0;
            pulls++;
        end
        if (fl) begin
            clear_window();
            for (int k = 0; k < NREQ; k++) begin
                m_credit[k] = 0;
                obs_out[k]  = 0;
            end
        end
        exp_rv  = nrv;
        exp_rid = nid;
        exp_rq  = nq;
    endtask

    // One 4-cycle divider slot: pull and push share the first cycle.
    task automatic slot(input logic [NREQ-1:0] v, input bit fl = 1'b0);
        step(1'b1, 1'b1, fl, v);
        repeat (3) step(1'b0, 1'b0, 1'b0, v);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        pulls  = 0;
        n_pulses = 0;
        last_id = 0;
        last_q = '0;
        last_ready = '0;
        for (int j = 0; j < NSLOT; j++) begin
            s_valid[j] = 1'b0;
            s_id[j]    = 0;
            s_q[j]     = '0;
            divq[j]    = '0;
        end
        for (int k = 0; k < NREQ; k++) begin
            opd[k] = '0;
            ops[k] = '0;
        end
        rst = 1'b0;
        flush = 1'b0;
        req_valid = '0;
        div_pull = 1'b0;
        div_push = 1'b0;
        div_quotient = '0;
        req_dividend = '0;
        req_divisor = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst = 1'b1;

        // Signed single request from requester 1.
        opd[1] = -21'sd100;
        ops[1] = 12'sd7;
        n_pulses = 0;
        slot(2'b10);
        repeat (11) slot(2'b00);
        chk("signed_pulses", n_pulses, 1);
        chk("signed_id", last_id, 1);
        chk("signed_q", last_q, 22'h3FFC6E);

        // Single request from requester 0; leaves the pointer at 0.
        opd[0] = 21'sd100;
        ops[0] = 12'sd7;
        n_pulses = 0;
        slot(2'b01);
        repeat (11) slot(2'b00);
        chk("single_pulses", n_pulses, 1);
        chk("single_id", last_id, 0);
        chk("single_q", last_q, 914);
        chk("single_busy_low", busy, 0);

        // Both requesters contend: grants alternate starting with requester 1.
        n_pulses = 0;
        for (int s = 0; s < 6; s++) begin
            for (int k = 0; k < NREQ; k++) begin
                opd[k] = DW'(s * 37 + k * 1000 + 5);
                ops[k] = SW'(3 + s + k);
            end
            slot(2'b11);
            chk("alt_grant", last_ready, (s % 2 == 0) ? 2'b10 : 2'b01);
        end
        repeat (11) slot(2'b00);
        chk("alt_pulses", n_pulses, 6);

        // Credit limit: three grants, stall until the first result, then refill.
        opd[0] = 21'sd5000;
        ops[0] = -12'sd9;
        for (int s = 0; s < 13; s++) begin
            slot(2'b01);
            chk("credit_grant", last_ready, (s < 3 || s >= 10) ? 2'b01 : 2'b00);
        end
        repeat (11) slot(2'b00);

        // Flush drops three in-flight grants; a new request right after returns.
        n_pulses = 0;
        opd[0] = 21'sd777;
        ops[0] = 12'sd11;
        repeat (3) slot(2'b01);
        slot(2'b00);
        slot(2'b01, 1'b1);
        chk("flush_ready_low", last_ready, 2'b00);
        opd[0] = 21'sd1234;
        ops[0] = 12'sd5;
        slot(2'b01);
        chk("flush_regrant", last_ready, 2'b01);
        repeat (11) slot(2'b00);
        chk("flush_pulses", n_pulses, 1);
        chk("flush_last_q", last_q, qf(21'sd1234, 12'sd5));

        // Randomized traffic with occasional flushes.
        for (int s = 0; s < 120; s++) begin
            for (int k = 0; k < NREQ; k++) begin
                opd[k] = DW'($urandom);
                ops[k] = SW'($urandom_range(1, 2047));
                if ($urandom_range(0, 1) == 1) ops[k] = -ops[k];
            end
            slot(NREQ'($urandom_range(0, 3)), $urandom_range(0, 29) == 0);
        end
        repeat (11) slot(2'b00);

        // Asynchronous reset with four tags in flight.
        repeat (4) slot(2'b11);
        chk("pre_reset_busy", busy, 1);
        @(negedge clk);
        div_pull = 1'b1;
        div_push = 1'b1;
        req_valid = 2'b11;
        #2;
        rst = 1'b0;
        #1;
        check_zero("midreset");
        div_pull = 1'b0;
        div_push = 1'b0;
        req_valid = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        model_reset();
        n_pulses = 0;
        opd[1] = 21'sd300;
        ops[1] = 12'sd3;
        slot(2'b11);
        chk("post_reset_first", last_ready, 2'b10);
        repeat (11) slot(2'b00);
        chk("post_reset_pulses", n_pulses, 1);
        chk("post_reset_id", last_id, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/div_sched.md
Name: div_sched

Overview:
- Shares one free-running pipelined divider (4-cycle slot, pull/push strobes) between NREQ requesters, e.g. the triangle-setup slope units.
- Arbitrates round-robin once per slot and drives the divider's dividend/divisor, which stay constant for the whole slot.
- Tracks in-flight slots with a tag shift register and routes each quotient back to its requester with an ID.
- Enforces a per-requester outstanding-result credit, because results cannot be back-pressured.

Parameters:
- NREQ, 2, number of requesters (2..8)
- IDW, 1, requester ID width, equal to clog2(NREQ), minimum 1
- DIVIDEND_WIDTH, 21, dividend width (two's complement)
- DIVISOR_WIDTH, 12, divisor width (two's complement)
- OUTPUT_WIDTH, 22, quotient width
- PIPE_SLOTS, 9, number of div_pull strobes from operand capture to the div_push that presents that operand's quotient
- MAX_OUT, 3, maximum in-flight results per requester (1..PIPE_SLOTS)

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous, active-low reset
- flush  input  1  synchronous; drops all in-flight tags
- req_valid  input  NREQ  per-requester request
- req_ready  output  NREQ  one-hot grant; a transfer occurs when valid and ready are both 1
- req_dividend  input  NREQ*DIVIDEND_WIDTH  flat bus; requester k occupies slice k
- req_divisor  input  NREQ*DIVISOR_WIDTH  flat bus; requester k occupies slice k
- div_dividend  output  DIVIDEND_WIDTH  registered operand to the divider
- div_divisor  output  DIVISOR_WIDTH  registered operand to the divider
- div_pull  input  1  divider strobe: capture operands for a new slot
- div_push  input  1  divider strobe: div_quotient holds a slot result
- div_quotient  input  OUTPUT_WIDTH  divider result
- res_valid  output  1  one-cycle result pulse
- res_id  output  IDW  destination requester of the result
- res_quotient  output  OUTPUT_WIDTH  result value
- busy  output  1  high when any tag in flight is valid

Behaviour:
- Reset (rst low, asynchronous):
  - req_ready, res_valid, res_id, res_quotient, div_dividend, div_divisor, busy: all 0.
  - Tags invalid, credit counters 0, round-robin pointer 0.
- Arbitration is combinational in the div_pull cycle only; req_ready is 0 in every other cycle.
- Eligible requester: req_valid high and credit count below MAX_OUT.
- Search order starts at pointer+1 mod NREQ and wraps. The winner gets req_ready high for that cycle.
- The pointer updates to the winner only on a grant.
- On a grant, div_dividend/div_divisor load the winner's slices at the next clock edge and hold until the next grant.
- With no winner, the operands keep their previous values (the idle slot computes garbage) and an invalid tag is inserted.
- Tag shift register:
  - PIPE_SLOTS entries of {valid, id}; shifts on every div_pull.
  - The entry inserted at a pull reaches the tail PIPE_SLOTS pulls later.
- On div_push, the tail entry is examined.
  - If valid: next cycle res_valid=1, res_id=tag id, res_quotient=div_quotient registered; the requester's credit is decremented.
  - If invalid: no pulse.
- A grant and a result for the same requester in the same cycle leave its credit unchanged.
- The credit counter never underflows; a decrement at 0 is an error that a bench assertion checks.
- div_pull and div_push asserted in the same cycle is legal: the push consumes the pre-shift tail.
- flush:
  - Clears all tag valids and credits.
  - Suppresses the res_valid pulse in the cycle after flush.
  - Forces req_ready to 0 in the flush cycle.
  - Keeps operand registers and the pointer.
- busy = OR of the tag valids.
- Reset asserted mid-operation discards everything; behaviour after release matches power-up.
- req_dividend/req_divisor need be stable only in the grant cycle.
- Sign handling and fixed-point scaling belong to the divider; this block passes data through unchanged.

Test Plan:
- Single request, requester 0: 100 / 7 with OUTPUT_FRAC=6.
  - Required: exactly one res_valid, res_id=0, res_quotient=914, on the cycle after the PIPE_SLOTS-th subsequent div_push.
  - Required: busy falls afterwards.
- Signed request, requester 1: -100 / 7.
  - Required: res_quotient = -914 (two's complement 22-bit 0x3FFC6E), res_id=1.
- Both requesters hold req_valid for 6 slots with distinct operands.
  - Required: grants alternate 1,0,1,0,1,0 starting from pointer 0.
  - Required: results return in grant order with the correct ids.
- Requester 0 alone, continuously valid, MAX_OUT=3.
  - Required: grants in 3 consecutive slots, then none until the first result.
  - Required: thereafter one grant per returned result.
  - Required: in-flight count never exceeds 3.
- flush two slots after three grants.
  - Required: no res_valid for those grants; credits return to 0.
  - Required: a new request issued immediately after returns normally.
- Reset pulse with 4 tags in flight.
  - Required: all outputs 0 immediately (asynchronous), no stale results after release.
  - Required: first post-reset grant goes to requester 1 when both requesters request.
